// File: rtl/sigma_pkg.sv
// Shared constants, state encoding and fixed-point helpers for the sigma-point stages.
package sigma_pkg;

  localparam int N_STATE   = 5;
  localparam int N_SIGMA   = 11;
  localparam int N_TRI     = 15;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EMIT_MEAN  = 3'd1,
    SCALE      = 3'd2,
    EMIT_PLUS  = 3'd3,
    EMIT_MINUS = 3'd4
  } state_t;

  // Packed slot of L(i,j) with 0-based row i and column j, j <= i.
  function automatic int tri_idx(input int i, input int j);
    return (i * (i + 1)) / 2 + j;
  endfunction

  // Clamp a signed value to the range of a w-bit two's-complement word (w <= 32).
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational Q-format multiply: full signed product, arithmetic shift by FRAC,
// saturation back to WIDTH bits.
module fx_mul_sat
  import sigma_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;

  assign a_ext   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod    = a_ext * b_ext;
  // Arithmetic shift truncates toward minus infinity.
  assign shifted = prod >>> FRAC;
  assign p       = WIDTH'(sat_w(64'(shifted), WIDTH));

endmodule

// File: rtl/sigma_gen_5.sv
// Serial sigma-point generator for a 5-state filter: emits x, then x +/- gamma*L(:,j)
// for each column j, one 5-vector per output beat through a single shared multiplier.
module sigma_gen_5
  import sigma_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic [N_TRI*WIDTH-1:0]   L,
  input  logic                     L_valid,
  input  logic [N_STATE*WIDTH-1:0] x,
  input  logic [WIDTH-1:0]         gamma,
  output logic                     in_ready,
  output logic [N_STATE*WIDTH-1:0] chi,
  output logic [3:0]               chi_idx,
  output logic                     chi_valid,
  output logic                     chi_last,
  input  logic                     chi_ready,
  output logic [2:0]               dbg_state
);

  localparam logic [2:0] ST_IDLE       = IDLE;
  localparam logic [2:0] ST_EMIT_MEAN  = EMIT_MEAN;
  localparam logic [2:0] ST_SCALE      = SCALE;
  localparam logic [2:0] ST_EMIT_PLUS  = EMIT_PLUS;
  localparam logic [2:0] ST_EMIT_MINUS = EMIT_MINUS;
  localparam logic [2:0] LAST_ROW      = 3'(N_STATE - 1);

  logic [2:0]                 state;
  logic [2:0]                 col;
  logic [2:0]                 row;
  logic [N_TRI*WIDTH-1:0]     l_q;
  logic [N_STATE*WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]           gamma_q;
  logic [WIDTH-1:0]           s_q   [N_STATE];
  logic [WIDTH-1:0]           s_cur [N_STATE];
  logic [WIDTH-1:0]           l_sel;
  logic [WIDTH-1:0]           mul_p;
  logic [N_STATE*WIDTH-1:0]   chi_plus;
  logic [N_STATE*WIDTH-1:0]   chi_minus;
  logic                       hs;

  function automatic logic [WIDTH-1:0] add_sat(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic sub);
    logic signed [WIDTH:0] ae;
    logic signed [WIDTH:0] be;
    logic signed [WIDTH:0] t;
    ae = {a[WIDTH-1], a};
    be = {b[WIDTH-1], b};
    t  = sub ? (ae - be) : (ae + be);
    return WIDTH'(sat_w(64'(t), WIDTH));
  endfunction

  // Output stream: a beat transfers on an enabled edge with chi_valid & chi_ready;
  // chi, chi_idx and chi_last hold while chi_valid is high and chi_ready is low.
  assign hs        = chi_valid & chi_ready;
  assign in_ready  = (state == ST_IDLE);
  assign dbg_state = state;

  // Entries above the diagonal read as zero so every column takes the same 5 cycles.
  always_comb begin
    l_sel = '0;
    if (row >= col) l_sel = l_q[tri_idx(int'(row), int'(col))*WIDTH +: WIDTH];
  end

  fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
    .a(gamma_q),
    .b(l_sel),
    .p(mul_p)
  );

  // The last scale product is forwarded so chi_plus is ready on the SCALE exit edge.
  always_comb begin
    chi_plus  = '0;
    chi_minus = '0;
    for (int r = 0; r < N_STATE; r++) begin
      s_cur[r] = (state == ST_SCALE && row == 3'(r)) ? mul_p : s_q[r];
      chi_plus[r*WIDTH +: WIDTH]  = add_sat(x_q[r*WIDTH +: WIDTH], s_cur[r], 1'b0);
      chi_minus[r*WIDTH +: WIDTH] = add_sat(x_q[r*WIDTH +: WIDTH], s_cur[r], 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      col       <= '0;
      row       <= '0;
      l_q       <= '0;
      x_q       <= '0;
      gamma_q   <= '0;
      chi       <= '0;
      chi_idx   <= '0;
      chi_valid <= 1'b0;
      chi_last  <= 1'b0;
      for (int r = 0; r < N_STATE; r++) s_q[r] <= '0;
    end else if (clk_en) begin
      case (state)
        ST_IDLE: begin
          if (L_valid) begin
            l_q       <= L;
            x_q       <= x;
            gamma_q   <= gamma;
            chi       <= x;
            chi_idx   <= '0;
            chi_valid <= 1'b1;
            chi_last  <= 1'b0;
            state     <= ST_EMIT_MEAN;
          end
        end
        ST_EMIT_MEAN: begin
          if (hs) begin
            chi_valid <= 1'b0;
            col       <= '0;
            row       <= '0;
            state     <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          s_q[row] <= mul_p;
          if (row == LAST_ROW) begin
            row       <= '0;
            chi       <= chi_plus;
            chi_idx   <= {col, 1'b1};
            chi_valid <= 1'b1;
            chi_last  <= 1'b0;
            state     <= ST_EMIT_PLUS;
          end else begin
            row <= row + 3'd1;
          end
        end
        ST_EMIT_PLUS: begin
          if (hs) begin
            chi      <= chi_minus;
            chi_idx  <= chi_idx + 4'd1;
            chi_last <= (col == LAST_ROW);
            state    <= ST_EMIT_MINUS;
          end
        end
        ST_EMIT_MINUS: begin
          if (hs) begin
            chi_valid <= 1'b0;
            chi_last  <= 1'b0;
            if (col == LAST_ROW) begin
              state <= ST_IDLE;
            end else begin
              col   <= col + 3'd1;
              row   <= '0;
              state <= ST_SCALE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigma_gen_5.sv
// Directed bench for sigma_gen_5: scoreboarded beats, hand-computed spot values,
// backpressure, saturation, flow control, clock-enable stalls and mid-set reset.
module tb_sigma_gen_5;

  localparam int W  = 32;
  localparam int BW = 165;  // {chi_last, chi_idx, chi}

  logic            clk;
  logic            rst_n;
  logic            clk_en;
  logic [15*W-1:0] L;
  logic            L_valid;
  logic [5*W-1:0]  x;
  logic [W-1:0]    gamma;
  logic            in_ready;
  logic [5*W-1:0]  chi;
  logic [3:0]      chi_idx;
  logic            chi_valid;
  logic            chi_last;
  logic            chi_ready;
  logic [2:0]      dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int n_acc    = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int last_cyc = 0;
  int rdy_mode = 0;
  int stall_n  = 0;
  logic busy       = 1'b0;
  logic prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] cap_q[$];

  sigma_gen_5 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .L        (L),
    .L_valid  (L_valid),
    .x        (x),
    .gamma    (gamma),
    .in_ready (in_ready),
    .chi      (chi),
    .chi_idx  (chi_idx),
    .chi_valid(chi_valid),
    .chi_last (chi_last),
    .chi_ready(chi_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] m_sat(input logic signed [63:0] v);
    if (v > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (v < -64'sh80000000) return 32'h80000000;
    return v[31:0];
  endfunction

  function automatic logic [W-1:0] m_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] p;
    p = 64'($signed(a)) * 64'($signed(b));
    p = p >>> 16;
    return m_sat(p);
  endfunction

  function automatic logic [W-1:0] m_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic signed [63:0] t;
    t = sub ? (64'($signed(a)) - 64'($signed(b))) : (64'($signed(a)) + 64'($signed(b)));
    return m_sat(t);
  endfunction

  task automatic push_set();
    for (int k = 0; k < 11; k++) begin
      logic [5*W-1:0] v;
      int j;
      j = (k - 1) / 2;
      for (int r = 0; r < 5; r++) begin
        logic [W-1:0] xr;
        logic [W-1:0] s;
        xr = x[r*W +: W];
        s  = (k == 0 || r < j) ? '0 : m_mul(gamma, L[((r * (r + 1)) / 2 + j)*W +: W]);
        v[r*W +: W] = (k == 0) ? xr : m_add(xr, s, (k % 2) == 0);
      end
      exp_q.push_back({(k == 10), 4'(k), v});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [BW-1:0] beat;
    if (!rst_n) begin
      exp_q.delete();
      busy       = 1'b0;
      prev_stall = 1'b0;
    end else begin
      beat = {chi_last, chi_idx, chi};
      check("in_ready", BW'(in_ready), BW'(!busy));
      if (prev_stall) begin
        check("stall_valid", BW'(chi_valid), BW'(1));
        check("stall_hold", beat, prev_beat);
      end
      if (clk_en && chi_valid && chi_ready) begin
        cap_q.push_back(beat);
        check("beat_expected", BW'(busy), BW'(1));
        if (exp_q.size() > 0) check("beat", beat, exp_q.pop_front());
        if (chi_last) begin
          busy     = 1'b0;
          last_cyc = cyc;
        end
      end
      if (clk_en && in_ready && L_valid) begin
        push_set();
        busy    = 1'b1;
        acc_cyc = cyc + 1;
        n_acc++;
      end
      prev_stall = chi_valid && !chi_ready;
      prev_beat  = beat;
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) begin
        if (chi_valid && chi_idx == 4'd3 && stall_n < 3) begin
          chi_ready = 1'b0;
          stall_n++;
        end else begin
          chi_ready = !chi_ready;
        end
      end else begin
        chi_ready = 1'b1;
      end
    end
  end

  task automatic accept_set(input logic [15*W-1:0] l_in, input logic [5*W-1:0] x_in,
                            input logic [W-1:0] g_in);
    int start;
    int t;
    cap_q.delete();
    @(posedge clk); #1;
    L = l_in; x = x_in; gamma = g_in; L_valid = 1'b1;
    start = n_acc;
    t = 0;
    while (n_acc == start && t < 20) begin @(posedge clk); #1; t++; end
    L_valid = 1'b0;
    check("accepted", BW'(n_acc - start), BW'(1));
  endtask

  task automatic run_set(input logic [15*W-1:0] l_in, input logic [5*W-1:0] x_in,
                         input logic [W-1:0] g_in);
    int t;
    accept_set(l_in, x_in, g_in);
    t = 0;
    while (busy && t < 400) begin @(posedge clk); #1; t++; end
    check("set_done", BW'(busy), BW'(0));
    check("beat_count", BW'(cap_q.size()), BW'(11));
  endtask

  // ---------------- stimulus ----------------
  logic [15*W-1:0] l_diag;
  logic [15*W-1:0] l_full;
  logic [15*W-1:0] l_one;
  logic [5*W-1:0]  x_mix;
  localparam logic [31:0] ONE = 32'h00010000;

  initial begin
    int t;
    int start;
    int t0;
    rst_n = 1'b0; clk_en = 1'b1; L_valid = 1'b0; chi_ready = 1'b1;
    L = '0; x = '0; gamma = '0;
    l_diag = '0;
    for (int i = 0; i < 5; i++) l_diag[((i * (i + 1)) / 2 + i)*W +: W] = 32'h00020000;
    l_full = {15{ONE}};
    x_mix  = {32'h00050000, 32'hFFFD0000, 32'h00000000, 32'h00028000, 32'h00010000};

    repeat (2) @(posedge clk); #1;
    check("rst_in_ready", BW'(in_ready), BW'(1));
    check("rst_chi_valid", BW'(chi_valid), BW'(0));
    check("rst_chi_last", BW'(chi_last), BW'(0));
    check("rst_chi", BW'(chi), BW'(0));
    check("rst_chi_idx", BW'(chi_idx), BW'(0));
    check("rst_state", BW'(dbg_state), BW'(0));
    #2 rst_n = 1'b1;

    // Basic set: diagonal 2.0, x = 1.0, gamma = 1.5
    run_set(l_diag, {5{ONE}}, 32'h00018000);
    check("basic_latency", BW'(last_cyc - acc_cyc), BW'(35));
    if (cap_q.size() == 11) begin
      check("basic_chi0", cap_q[0], {1'b0, 4'd0, {5{ONE}}});
      check("basic_chi1", cap_q[1], {1'b0, 4'd1, {4{ONE}}, 32'h00040000});
      check("basic_chi2_x1", BW'(cap_q[2][31:0]), BW'(32'hFFFE0000));
      check("basic_chi3", cap_q[3], {1'b0, 4'd3, {3{ONE}}, 32'h00040000, ONE});
      check("basic_chi10", cap_q[10], {1'b1, 4'd10, 32'hFFFE0000, {4{ONE}}});
    end
    check("in_ready_after_last", BW'(in_ready), BW'(1));

    // Full lower triangle of ones, x = 0, gamma = 1.0
    run_set(l_full, '0, ONE);
    if (cap_q.size() == 11) begin
      check("tri_chi1", BW'(cap_q[1][159:0]), BW'({5{ONE}}));
      check("tri_chi5", BW'(cap_q[5][159:0]), BW'({ONE, ONE, ONE, 64'h0}));
      check("tri_chi6", BW'(cap_q[6][159:0]), BW'({{3{32'hFFFF0000}}, 64'h0}));
      check("tri_chi10", BW'(cap_q[10][159:0]), BW'({32'hFFFF0000, 128'h0}));
    end

    // Backpressure: toggling ready, 3-cycle stall on beat 3
    rdy_mode = 1; stall_n = 0;
    run_set(l_diag, x_mix, 32'h00018000);
    rdy_mode = 0;
    check("bp_stalls", BW'(stall_n), BW'(3));
    for (int k = 0; k < cap_q.size(); k++) check("bp_idx", BW'(cap_q[k][163:160]), BW'(k));

    // Add/sub and multiply saturation, truncation toward minus infinity
    l_one = '0; l_one[31:0] = 32'h00020000;
    run_set(l_one, {128'h0, 32'h7FFF0000}, ONE);
    if (cap_q.size() == 11) check("sat_pos", BW'(cap_q[1][31:0]), BW'(32'h7FFFFFFF));
    run_set(l_one, {128'h0, 32'h80010000}, ONE);
    if (cap_q.size() == 11) begin
      check("sat_plus_in_range", BW'(cap_q[1][31:0]), BW'(32'h80030000));
      check("sat_neg", BW'(cap_q[2][31:0]), BW'(32'h80000000));
    end
    l_one[31:0] = 32'h7FFF0000;
    run_set(l_one, '0, 32'h7FFF0000);
    if (cap_q.size() == 11) begin
      check("mul_sat_plus", BW'(cap_q[1][31:0]), BW'(32'h7FFFFFFF));
      check("mul_sat_minus", BW'(cap_q[2][31:0]), BW'(32'h80000001));
    end
    l_one[31:0] = 32'h00008000;
    run_set(l_one, '0, 32'hFFFFFFFF);
    if (cap_q.size() == 11) begin
      check("trunc_plus", BW'(cap_q[1][31:0]), BW'(32'hFFFFFFFF));
      check("trunc_minus", BW'(cap_q[2][31:0]), BW'(32'h00000001));
    end

    // Flow control: L_valid held high ~200 cycles, inputs changed mid-set, clk_en gap
    @(posedge clk); #1;
    L = l_full; x = {5{32'h00020000}}; gamma = ONE; L_valid = 1'b1;
    start = n_acc; t0 = cyc;
    t = 0;
    while (n_acc == start && t < 20) begin @(posedge clk); #1; t++; end
    L = l_diag; x = x_mix; gamma = 32'h00018000;
    t = 0;
    while (n_acc < start + 2 && t < 100) begin @(posedge clk); #1; t++; end
    check("flow_second_accept", BW'(n_acc - start), BW'(2));
    t = 0;
    while (dbg_state != 3'd2 && t < 20) begin @(posedge clk); #1; t++; end
    check("flow_in_scale", BW'(dbg_state), BW'(2));
    clk_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 clk_en = 1'b1;
    t = 0;
    while (busy && t < 100) begin @(posedge clk); #1; t++; end
    check("flow_latency", BW'(last_cyc - acc_cyc), BW'(39));
    while (cyc - t0 < 200) begin @(posedge clk); #1; end
    L_valid = 1'b0;
    t = 0;
    while (busy && t < 100) begin @(posedge clk); #1; t++; end
    check("flow_done", BW'(busy), BW'(0));
    check("flow_accepts", BW'(n_acc - start), BW'(6));

    // Reset during EMIT_PLUS of column 2
    accept_set(l_full, {5{ONE}}, ONE);
    t = 0;
    while (!(chi_valid && chi_idx == 4'd5) && t < 60) begin @(posedge clk); #1; t++; end
    check("reached_col2_plus", BW'(chi_idx), BW'(5));
    #2 rst_n = 1'b0;
    #1;
    check("abort_chi_valid", BW'(chi_valid), BW'(0));
    check("abort_in_ready", BW'(in_ready), BW'(1));
    check("abort_chi_last", BW'(chi_last), BW'(0));
    check("abort_chi", BW'(chi), BW'(0));
    check("abort_chi_idx", BW'(chi_idx), BW'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check("release_in_ready", BW'(in_ready), BW'(1));
    run_set(l_diag, {5{ONE}}, 32'h00018000);
    if (cap_q.size() == 11) begin
      check("post_rst_chi0", cap_q[0], {1'b0, 4'd0, {5{ONE}}});
      check("post_rst_chi1", cap_q[1], {1'b0, 4'd1, {4{ONE}}, 32'h00040000});
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
